// File: rtl/uart_perip_ctrl_if.sv
// Peripheral-memory port used by the UART engine: a combinational read port
// and a single full-word write port.
interface uart_perip_ctrl_if;
  logic [31:0] rdaddr_perip_o;
  logic [31:0] data_perip_i;
  logic        write_perip_o;
  logic [31:0] wraddr_perip_o;
  logic [31:0] data_perip_o;

  // UART engine side
  modport master (
    output rdaddr_perip_o,
    input  data_perip_i,
    output write_perip_o,
    output wraddr_perip_o,
    output data_perip_o
  );

  // Peripheral memory side
  modport slave (
    input  rdaddr_perip_o,
    output data_perip_i,
    input  write_perip_o,
    input  wraddr_perip_o,
    input  data_perip_o
  );
endinterface

// File: rtl/uart_perip_ctrl.sv
// UART engine (8N1, LSB first) living behind the peripheral register memory.
// Polls CTRL/BAUD/TX_REQ/RX_ACK words and writes STATUS, RX_DATA and the
// request clears back through a single prioritised write port.
module uart_perip_ctrl #(
  parameter logic [31:0] BASE    = 32'h0,
  parameter int unsigned MIN_DIV = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  uart_perip_ctrl_if.master  mem,
  input  logic               uart_rx_i,
  output logic               uart_tx_o
);

  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_BAUD   = 32'h04;
  localparam logic [31:0] OFF_TXDATA = 32'h08;
  localparam logic [31:0] OFF_TXREQ  = 32'h0C;
  localparam logic [31:0] OFF_STATUS = 32'h10;
  localparam logic [31:0] OFF_RXDATA = 32'h14;
  localparam logic [31:0] OFF_RXACK  = 32'h18;
  localparam logic [15:0] MIN_DIV_W  = 16'(MIN_DIV);

  typedef enum logic [2:0] {SLOT_CTRL, SLOT_BAUD, SLOT_TXREQ, SLOT_RXACK, SLOT_TXDATA} slot_e;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} bit_fsm_e;

  slot_e       slot_q, slot_d;
  logic        tx_en_q, tx_en_d, rx_en_q, rx_en_d;
  logic [15:0] baud_q, baud_d;
  bit_fsm_e    tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic        tx_line_q, tx_line_d;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, frame_err_q, frame_err_d;
  logic        pend_rxdata_q, pend_rxdata_d, pend_status_q, pend_status_d;
  logic        pend_txclr_q, pend_txclr_d, pend_ackclr_q, pend_ackclr_d;

  logic [15:0] eff_div;
  logic [3:0]  status_now, status_nxt;
  logic        issue_rxdata, issue_status, issue_txclr, issue_ackclr;
  logic        start_tx, ack, deliver, stop_bad;
  logic        unused_rd_bits;

  assign eff_div        = (baud_q < MIN_DIV_W) ? MIN_DIV_W : baud_q;
  assign status_now     = {frame_err_q, rx_overrun_q, rx_valid_q, tx_state_q != ST_IDLE};
  assign uart_tx_o      = tx_line_q;
  assign unused_rd_bits = ^mem.data_perip_i[31:16];

  // Fixed-priority write arbiter: RX_DATA > STATUS > TXREQ_CLR > RXACK_CLR
  always_comb begin
    issue_rxdata = pend_rxdata_q;
    issue_status = pend_status_q & ~pend_rxdata_q;
    issue_txclr  = pend_txclr_q & ~pend_rxdata_q & ~pend_status_q;
    issue_ackclr = pend_ackclr_q & ~pend_rxdata_q & ~pend_status_q & ~pend_txclr_q;
    mem.write_perip_o  = pend_rxdata_q | pend_status_q | pend_txclr_q | pend_ackclr_q;
    mem.wraddr_perip_o = BASE + OFF_RXACK;
    mem.data_perip_o   = 32'h0;
    if (issue_rxdata) begin
      mem.wraddr_perip_o = BASE + OFF_RXDATA;
      mem.data_perip_o   = {24'h0, rx_data_q};
    end else if (issue_status) begin
      mem.wraddr_perip_o = BASE + OFF_STATUS;
      mem.data_perip_o   = {28'h0, status_now};
    end else if (issue_txclr) begin
      mem.wraddr_perip_o = BASE + OFF_TXREQ;
    end
  end

  // Read address follows the poll slot
  always_comb begin
    case (slot_q)
      SLOT_BAUD:   mem.rdaddr_perip_o = BASE + OFF_BAUD;
      SLOT_TXREQ:  mem.rdaddr_perip_o = BASE + OFF_TXREQ;
      SLOT_RXACK:  mem.rdaddr_perip_o = BASE + OFF_RXACK;
      SLOT_TXDATA: mem.rdaddr_perip_o = BASE + OFF_TXDATA;
      default:     mem.rdaddr_perip_o = BASE + OFF_CTRL;
    endcase
  end

  // Next-state logic: poll sequencer, TX/RX bit engines, status and pending flags
  always_comb begin
    slot_d = slot_q; tx_en_d = tx_en_q; rx_en_d = rx_en_q; baud_d = baud_q;
    tx_state_d = tx_state_q; tx_shift_d = tx_shift_q; tx_cnt_d = tx_cnt_q;
    tx_div_d = tx_div_q; tx_bit_d = tx_bit_q; tx_line_d = tx_line_q;
    rx_state_d = rx_state_q; rx_shift_d = rx_shift_q; rx_cnt_d = rx_cnt_q;
    rx_div_d = rx_div_q; rx_bit_d = rx_bit_q; rx_data_d = rx_data_q;
    rx_s1_d = uart_rx_i; rx_s2_d = rx_s1_q; rx_prev_d = rx_s2_q;
    rx_valid_d = rx_valid_q; rx_overrun_d = rx_overrun_q; frame_err_d = frame_err_q;
    start_tx = 1'b0; ack = 1'b0; deliver = 1'b0; stop_bad = 1'b0;
    pend_rxdata_d = pend_rxdata_q & ~issue_rxdata;
    pend_status_d = pend_status_q & ~issue_status;
    pend_txclr_d  = pend_txclr_q & ~issue_txclr;
    pend_ackclr_d = pend_ackclr_q & ~issue_ackclr;

    case (slot_q)
      SLOT_CTRL: begin
        tx_en_d = mem.data_perip_i[0];
        rx_en_d = mem.data_perip_i[1];
        slot_d  = SLOT_BAUD;
      end
      SLOT_BAUD: begin
        baud_d = mem.data_perip_i[15:0];
        slot_d = SLOT_TXREQ;
      end
      SLOT_TXREQ: begin
        // A still-queued clear means the word in memory is stale; ignore it
        if (mem.data_perip_i[0] && tx_en_q && tx_state_q == ST_IDLE && !pend_txclr_q)
          slot_d = SLOT_TXDATA;
        else
          slot_d = SLOT_RXACK;
      end
      SLOT_RXACK: begin
        ack    = mem.data_perip_i[0] & ~pend_ackclr_q;
        slot_d = SLOT_CTRL;
      end
      default: begin
        start_tx     = 1'b1;
        tx_shift_d   = mem.data_perip_i[7:0];
        pend_txclr_d = 1'b1;
        slot_d       = SLOT_CTRL;
      end
    endcase

    case (tx_state_q)
      ST_IDLE: begin
        tx_line_d = 1'b1;
        if (start_tx) begin
          tx_state_d = ST_START; tx_line_d = 1'b0;
          tx_cnt_d = 16'h0; tx_div_d = eff_div; tx_bit_d = 3'd0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d = 16'h0; tx_state_d = ST_DATA; tx_line_d = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      ST_DATA: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d = 16'h0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP; tx_line_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      default: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d = 16'h0; tx_state_d = ST_IDLE;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
    endcase

    if (!rx_en_q) rx_state_d = ST_IDLE;
    else begin
      case (rx_state_q)
        ST_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_d = ST_START; rx_cnt_d = 16'h0; rx_div_d = eff_div;
          end
        end
        ST_START: begin
          // Half-period delay lands later samples near the bit centres
          if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
            rx_cnt_d = 16'h0; rx_bit_d = 3'd0;
            rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
          end else rx_cnt_d = rx_cnt_q + 16'd1;
        end
        ST_DATA: begin
          if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_cnt_d = 16'h0;
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            else rx_bit_d = rx_bit_q + 3'd1;
          end else rx_cnt_d = rx_cnt_q + 16'd1;
        end
        default: begin
          if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_cnt_d = 16'h0; rx_state_d = ST_IDLE;
            deliver = 1'b1; stop_bad = ~rx_s2_q;
          end else rx_cnt_d = rx_cnt_q + 16'd1;
        end
      endcase
    end

    // Ack is applied before a same-cycle delivery so that byte is not an overrun
    if (ack) begin
      rx_valid_d = 1'b0; rx_overrun_d = 1'b0; frame_err_d = 1'b0;
      pend_status_d = 1'b1; pend_ackclr_d = 1'b1;
    end
    if (deliver) begin
      if (stop_bad) frame_err_d = 1'b1;
      if (!rx_valid_d) begin
        rx_data_d = rx_shift_q; rx_valid_d = 1'b1; pend_rxdata_d = 1'b1;
      end else rx_overrun_d = 1'b1;
    end

    status_nxt = {frame_err_d, rx_overrun_d, rx_valid_d, tx_state_d != ST_IDLE};
    if (status_nxt != status_now) pend_status_d = 1'b1;
  end

  // State registers; reset forces the TX line idle and drops queued writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= SLOT_CTRL; tx_en_q <= 1'b0; rx_en_q <= 1'b0; baud_q <= 16'h0;
      tx_state_q <= ST_IDLE; tx_shift_q <= 8'h0; tx_cnt_q <= 16'h0;
      tx_div_q <= 16'h0; tx_bit_q <= 3'd0; tx_line_q <= 1'b1;
      rx_state_q <= ST_IDLE; rx_shift_q <= 8'h0; rx_cnt_q <= 16'h0;
      rx_div_q <= 16'h0; rx_bit_q <= 3'd0; rx_data_q <= 8'h0;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_valid_q <= 1'b0; rx_overrun_q <= 1'b0; frame_err_q <= 1'b0;
      pend_rxdata_q <= 1'b0; pend_status_q <= 1'b0;
      pend_txclr_q <= 1'b0; pend_ackclr_q <= 1'b0;
    end else begin
      slot_q <= slot_d; tx_en_q <= tx_en_d; rx_en_q <= rx_en_d; baud_q <= baud_d;
      tx_state_q <= tx_state_d; tx_shift_q <= tx_shift_d; tx_cnt_q <= tx_cnt_d;
      tx_div_q <= tx_div_d; tx_bit_q <= tx_bit_d; tx_line_q <= tx_line_d;
      rx_state_q <= rx_state_d; rx_shift_q <= rx_shift_d; rx_cnt_q <= rx_cnt_d;
      rx_div_q <= rx_div_d; rx_bit_q <= rx_bit_d; rx_data_q <= rx_data_d;
      rx_s1_q <= rx_s1_d; rx_s2_q <= rx_s2_d; rx_prev_q <= rx_prev_d;
      rx_valid_q <= rx_valid_d; rx_overrun_q <= rx_overrun_d; frame_err_q <= frame_err_d;
      pend_rxdata_q <= pend_rxdata_d; pend_status_q <= pend_status_d;
      pend_txclr_q <= pend_txclr_d; pend_ackclr_q <= pend_ackclr_d;
    end
  end

endmodule

// File: doc/uart_perip_ctrl.md
Name: uart_perip_ctrl

Overview:
- UART engine on the peripheral side of the peripheral register memory.
- Polls its configuration and request words over the memory's combinational read port and writes status and received data back over the memory's single peripheral write port.
- Drives the serial TX line and samples the serial RX line (8N1, LSB first).
- Software sees only memory words; this block never touches the bus side.

Parameters:
- BASE, 32'h0, byte address of the first word (CTRL) of this UART's window in the peripheral memory; word aligned.
- MIN_DIV, 4, minimum effective bit period in clocks; smaller BAUD_DIV values are clamped to it.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rdaddr_perip_o  out  32  byte read address into peripheral memory
- data_perip_i  in  32  read data; combinational, valid in the same cycle
- write_perip_o  out  1  write strobe, full-word write
- wraddr_perip_o  out  32  byte write address
- data_perip_o  out  32  write data
- uart_rx_i  in  1  serial input, asynchronous
- uart_tx_o  out  1  serial output, idle high

Behaviour:
Reset state: uart_tx_o=1, write_perip_o=0, rdaddr_perip_o=BASE+0x00, all shadows, pending flags and status bits 0.

Register map (byte offsets from BASE):
- 0x00 CTRL: [0] tx_en, [1] rx_en
- 0x04 BAUD_DIV: [15:0]
- 0x08 TX_DATA: [7:0]
- 0x0C TX_REQ: [0], set by software, cleared by this block
- 0x10 STATUS: [0] tx_busy, [1] rx_valid, [2] rx_overrun, [3] frame_err; written only by this block
- 0x14 RX_DATA: [7:0]; written only by this block
- 0x18 RX_ACK: [0], set by software, cleared by this block

Poll sequencer:
- Slot FSM cycles CTRL -> BAUD -> TXREQ -> RXACK -> CTRL, one slot per clock.
- rdaddr_perip_o is a function of the slot register; data_perip_i is captured at the clock edge ending the slot.
- TXREQ slot, with read bit0=1, tx_en=1, TX FSM idle and no TX_REQ clear pending: next slot is TXDATA (0x08), then CTRL.
- TXDATA slot: latch the byte, start TX, queue the TX_REQ clear.
- RXACK slot, with read bit0=1: clear rx_valid, rx_overrun and frame_err; queue the RX_ACK clear and a STATUS write.
- Effective div = max(BAUD_DIV shadow, MIN_DIV). It is sampled at frame start and held for the whole frame.

Write arbiter:
- Pending flags, in priority order: RX_DATA > STATUS > TXREQ_CLR > RXACK_CLR.
- write_perip_o = OR of the pending flags. Address and data come combinationally from the highest-priority pending flag. That flag clears at the same edge.
- STATUS data is the live status vector in the issuing cycle.
- Any status-bit change sets STATUS pending. Re-setting an already pending flag merges into it; it is never lost.
- A same-cycle bus write to a word overrides this block's write. No retry.

TX FSM (IDLE, START, DATA, STOP):
- Each bit is held for div clocks; 8 data bits, LSB first; stop bit = 1.
- tx_busy=1 from TXDATA latch until the end of the stop bit.
- Clearing tx_en mid-frame does not abort the current frame.

RX path:
- 2-flop synchronizer on uart_rx_i.
- In IDLE with rx_en=1, a falling edge starts a frame. Sampling is at div/2 (integer), then every div clocks.
- Start bit sampled 1: return to IDLE silently.
- After 8 data bits, sample the stop bit. Stop=0 sets frame_err and still delivers the byte.
- Delivery with rx_valid=0: queue RX_DATA, set rx_valid.
- Delivery with rx_valid=1: set rx_overrun and discard the byte.
- Clearing rx_en aborts RX to IDLE within one clock.

Simultaneous events:
- RX_ACK clear and a new delivery in the same cycle: the ack is applied first, so the byte is delivered (no overrun).
- Reset mid-frame: uart_tx_o returns to 1 immediately, and pending writes are dropped.

Test Plan:
- Reset, mem CTRL=0x1, BAUD=8, TX_DATA=0xA5, TX_REQ=1:
  - TX_REQ is written 0 within 6 clocks.
  - uart_tx_o carries start, then 1,0,1,0,0,1,0,1, then stop, each bit 8 clocks.
  - STATUS writes 0x1, then 0x0 after the stop bit.
- BAUD=2: the bit period measures 4 clocks (clamp).
- CTRL=0x2, BAUD=16, 0x3C driven on uart_rx_i: RX_DATA written 0x3C before STATUS is written 0x2, in consecutive cycles.
- Second byte 0x55 sent without RX_ACK: STATUS written 0x6 and RX_DATA stays 0x3C. Then RX_ACK=1: STATUS written 0x0 and RX_ACK written 0.
- Stop bit driven 0 on a received 0xFF: RX_DATA=0xFF and STATUS=0xA.
- Assert rst_ni low mid-TX frame: uart_tx_o=1 and write_perip_o=0 asynchronously. After release, no spurious writes until software re-requests.
